// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined carry-lookahead subtractor (diff = a + ~b + 1).
// Optional saturation on signed overflow: define CLA_SUB_SAT_EN.
module cla_sub_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    localparam int NG  = WIDTH / GROUP;
    localparam int MSB = WIDTH - 1;

    if (GROUP != 4) begin : g_bad_group
        $error("cla_sub_pipe: GROUP must be 4");
    end
    if ((WIDTH % GROUP) != 0) begin : g_bad_width
        $error("cla_sub_pipe: WIDTH must be a multiple of GROUP");
    end

    // S1 state
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_nb;
    logic [WIDTH-1:0] r_s1_p;
    logic [WIDTH-1:0] r_s1_g;
    logic [NG-1:0]    r_s1_pg;
    logic [NG-1:0]    r_s1_gg;

    // S2 / output state
    logic             r_out_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_zero;

    // S1 combinational terms
    logic [WIDTH-1:0] w_nb;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [NG-1:0]    w_pg;
    logic [NG-1:0]    w_gg;

    // S2 combinational terms
    logic [NG:0]      w_gc;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_borrow;
    logic             w_zero;

    // Handshake
    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;

    // Top g bit of each group and all but the MSB of ~b only feed S1 terms
    logic             w_unused_s1;

    assign w_s2_adv   = !r_out_valid || out_ready_i;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign in_ready_o = w_s1_adv;
    assign w_accept   = in_valid_i && w_s1_adv;

    assign w_nb = ~b_i;
    assign w_p  = a_i ^ w_nb;
    assign w_g  = a_i & w_nb;

    assign w_unused_s1 = ^{r_s1_g, r_s1_nb};

    // Per-group propagate/generate from the per-bit terms
    always_comb begin
        w_pg = '0;
        w_gg = '0;
        for (int k = 0; k < NG; k++) begin
            w_pg[k] = &w_p[k*GROUP +: GROUP];
            w_gg[k] = w_g[k*GROUP+3]
                    | (w_p[k*GROUP+3] & w_g[k*GROUP+2])
                    | (w_p[k*GROUP+3] & w_p[k*GROUP+2] & w_g[k*GROUP+1])
                    | (w_p[k*GROUP+3] & w_p[k*GROUP+2]
                       & w_p[k*GROUP+1] & w_g[k*GROUP]);
        end
    end

    // Group carries (c_in = 1 supplies the +1), then ripple inside each group
    always_comb begin
        w_gc    = '0;
        w_gc[0] = 1'b1;
        for (int k = 0; k < NG; k++) begin
            w_gc[k+1] = r_s1_gg[k] | (r_s1_pg[k] & w_gc[k]);
        end
        w_c = '0;
        for (int k = 0; k < NG; k++) begin
            w_c[k*GROUP] = w_gc[k];
            for (int j = 0; j < GROUP - 1; j++) begin
                w_c[k*GROUP+j+1] = r_s1_g[k*GROUP+j]
                                 | (r_s1_p[k*GROUP+j] & w_c[k*GROUP+j]);
            end
        end
        w_sum = r_s1_p ^ w_c;
    end

    // b[MSB] != a[MSB] is the same as ~b[MSB] == a[MSB]
    assign w_ovf    = (r_s1_a[MSB] == r_s1_nb[MSB])
                   && (w_sum[MSB] != r_s1_a[MSB]);
    assign w_borrow = ~w_gc[NG];

`ifdef CLA_SUB_SAT_EN
    // Clamp toward the sign of the minuend on signed overflow
    always_comb begin
        w_res = w_sum;
        if (w_ovf) begin
            w_res = r_s1_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_res = w_sum;
`endif

    assign w_zero = ~|w_res;

    // S1 register: capture operands and lookahead terms on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_nb    <= '0;
            r_s1_p     <= '0;
            r_s1_g     <= '0;
            r_s1_pg    <= '0;
            r_s1_gg    <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid_i;
            end
            if (w_accept) begin
                r_s1_a  <= a_i;
                r_s1_nb <= w_nb;
                r_s1_p  <= w_p;
                r_s1_g  <= w_g;
                r_s1_pg <= w_pg;
                r_s1_gg <= w_gg;
            end
        end
    end

    // S2 register: result and flags; data holds when a bubble moves in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
            end
            if (w_s2_adv && r_s1_valid) begin
                r_diff   <= w_res;
                r_borrow <= w_borrow;
                r_ovf    <= w_ovf;
                r_zero   <= w_zero;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign diff_o      = r_diff;
    assign borrow_o    = r_borrow;
    assign ovf_o       = r_ovf;
    assign zero_o      = r_zero;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Bench for cla_sub_pipe: random and directed ops against an
// arithmetic reference model, with backpressure and reset cases.
module tb_cla_sub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] diff_o;
    logic        borrow_o;
    logic        ovf_o;
    logic        zero_o;
    logic        out_valid_o;
    logic        out_ready_i;

    int n_tot = 0;
    int n_bad = 0;
    int n_cyc = 0;
    bit chk_lat = 1'b0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int          qc[$];

    cla_sub_pipe #(.WIDTH(16), .GROUP(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_i         (a_i),
        .b_i         (b_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .diff_o      (diff_o),
        .borrow_o    (borrow_o),
        .ovf_o       (ovf_o),
        .zero_o      (zero_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // {borrow, ovf, zero, diff} from plain integer arithmetic
    function automatic logic [18:0] model(input logic [15:0] a,
                                          input logic [15:0] b);
        int          sa;
        int          sb;
        int          r;
        logic [15:0] d;
        logic        bo;
        logic        ov;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sa - sb;
        d  = a - b;
        bo = (a < b);
        ov = (r > 32767) || (r < -32768);
`ifdef CLA_SUB_SAT_EN
        if (r > 32767) d = 16'h7fff;
        else if (r < -32768) d = 16'h8000;
`endif
        return {bo, ov, (d == 16'h0), d};
    endfunction

    // One clock: drive at negedge, evaluate handshakes 1 time unit later
    task automatic cyc(input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic rdy,
                       output logic acc);
        logic [18:0] e;
        int          c;
        @(negedge clk);
        in_valid_i  = v;
        a_i         = a;
        b_i         = b;
        out_ready_i = rdy;
        #1;
        n_cyc++;
        acc = v && in_ready_o;
        if (out_valid_o && out_ready_i) begin
            if (qa.size() == 0) begin
                check("stray_out", 32'd1, 32'd0);
            end else begin
                e = model(qa.pop_front(), qb.pop_front());
                c = qc.pop_front();
                check("diff", {16'h0, diff_o}, {16'h0, e[15:0]});
                check("zero", {31'h0, zero_o}, {31'h0, e[16]});
                check("ovf", {31'h0, ovf_o}, {31'h0, e[17]});
                check("borrow", {31'h0, borrow_o}, {31'h0, e[18]});
                if (chk_lat) check("latency", n_cyc - c, 32'd2);
            end
        end
        if (acc) begin
            qa.push_back(a);
            qb.push_back(b);
            qc.push_back(n_cyc);
        end
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 20 && qa.size() != 0; i++) begin
            cyc(1'b0, 16'h0, 16'h0, 1'b1, a);
        end
        check("drain_empty", qa.size(), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [15:0] held;
        logic [18:0] e;
        int          t;
        logic [15:0] da[8];
        logic [15:0] db[8];
        logic [15:0] ra[3];
        logic [15:0] rb[3];

        da = '{16'h0005, 16'h0003, 16'h1234, 16'h8000,
               16'h7fff, 16'h0000, 16'habcd, 16'hffff};
        db = '{16'h0003, 16'h0005, 16'h1234, 16'h0001,
               16'hffff, 16'h0001, 16'h0000, 16'hffff};
        ra = '{16'h0100, 16'h8000, 16'h0042};
        rb = '{16'h0001, 16'h0001, 16'h0042};

        rst         = 1'b1;
        in_valid_i  = 1'b0;
        a_i         = '0;
        b_i         = '0;
        out_ready_i = 1'b0;

        // Reset state
        #2;
        check("rst_vld", {31'h0, out_valid_o}, 32'd0);
        check("rst_diff", {16'h0, diff_o}, 32'd0);
        check("rst_flags", {29'h0, borrow_o, ovf_o, zero_o}, 32'd0);
        check("rst_rdy", {31'h0, in_ready_o}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed ops including boundaries, no backpressure
        chk_lat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, da[i], db[i], 1'b1, acc);
            check("dir_acc", {31'h0, acc}, 32'd1);
        end
        drain();

        // Back-to-back random ops
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 16'($urandom), 16'($urandom), 1'b1, acc);
            check("b2b_rdy", {31'h0, acc}, 32'd1);
        end
        drain();

        // Backpressure: two fill the pipe, third stalls
        chk_lat = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t = 0;
            do begin
                cyc(1'b1, ra[i], rb[i], 1'b0, acc);
                t++;
            end while (!acc && t < 5);
            check("bp_acc", {31'h0, acc}, 32'd1);
        end
        held = '0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, ra[2], rb[2], 1'b0, acc);
            check("bp_rdy", {31'h0, in_ready_o}, 32'd0);
            check("bp_vld", {31'h0, out_valid_o}, 32'd1);
            if (i == 0) held = diff_o;
            else check("bp_hold", {16'h0, diff_o}, {16'h0, held});
        end
        e = model(ra[0], rb[0]);
        check("bp_val", {16'h0, held}, {16'h0, e[15:0]});
        t = 0;
        do begin
            cyc(1'b1, ra[2], rb[2], 1'b1, acc);
            t++;
        end while (!acc && t < 5);
        check("bp_acc3", {31'h0, acc}, 32'd1);
        drain();

        // Reset with two ops in flight
        chk_lat = 1'b1;
        cyc(1'b1, 16'h0010, 16'h0001, 1'b1, acc);
        cyc(1'b1, 16'h0020, 16'h0001, 1'b1, acc);
        @(negedge clk);
        check("pre_rst_vld", {31'h0, out_valid_o}, 32'd1);
        in_valid_i = 1'b0;
        rst        = 1'b1;
        #1;
        check("arst_vld", {31'h0, out_valid_o}, 32'd0);
        check("arst_diff", {16'h0, diff_o}, 32'd0);
        qa.delete();
        qb.delete();
        qc.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 16'h0, 16'h0, 1'b1, acc);
            check("no_stale", {31'h0, out_valid_o}, 32'd0);
        end
        cyc(1'b1, 16'h0009, 16'h0004, 1'b1, acc);
        check("post_rst_acc", {31'h0, acc}, 32'd1);
        drain();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
